link_arbiter: RTL and testbench

- Shares one 4-phase req/ack byte link (one slave) between N burst masters.
- Each master keeps its own req/ack/data/done interface and sees the link as private.
- Grant is burst-locked: it is held from grant until the master's done pulse and link drain.
- Round-robin selection between competing masters.

---
 rtl/link_arbiter.sv | 144 ++++++++++++++
 tb/tb_link_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_arbiter.sv
// Burst-locked round-robin arbiter sharing one 4-phase req/ack byte link among N masters.
// Grant registers one cycle after request; optional watchdog built with ARB_TIMEOUT_EN.
module link_arbiter #(
  parameter int N_MASTERS   = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data,
  input  logic [N_MASTERS-1:0]          m_done,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic                          s_req,
  output logic [DATA_W-1:0]             s_data,
  input  logic                          s_ack,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          busy,
  output logic                          timeout
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     pick_idx, cand;
  logic                 pick_vld;
  logic                 to_hit;

  // Scan farthest-to-nearest from rr so the nearest requester after rr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % N_MASTERS);
      if (m_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IDX_W'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gidx_d  = pick_idx;
          grant_d = N_MASTERS'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (m_done[gidx_q]) state_d = DRAIN;
      end
      DRAIN: begin
        // Release only once the link is quiescent so the next owner starts clean.
        if (!s_ack && !m_req[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = gidx_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    if (to_hit) begin
      state_d = IDLE;
      grant_d = '0;
      rr_d    = gidx_q;
    end
  end

  always_comb begin
    s_data = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) s_data = m_data[i*DATA_W +: DATA_W];
    end
    s_req = |(grant_q & m_req);
    m_ack = grant_q & {N_MASTERS{s_ack}};
    grant = grant_q;
    busy  = (state_q != IDLE);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            s_req_q, s_ack_q;
  logic            link_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      s_req_q <= 1'b0;
      s_ack_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      s_req_q <= s_req;
      s_ack_q <= s_ack;
    end
  end

  // Counter holds the number of consecutive quiet cycles while the link is owned.
  always_comb begin
    link_edge = (s_req != s_req_q) || (s_ack != s_ack_q);
    cnt_d     = '0;
    if (state_q != IDLE && !link_edge) cnt_d = cnt_q + 1'b1;
    to_hit    = (cnt_d == TO_W'(TIMEOUT_CYC));
  end

  assign timeout = to_hit;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_link_arbiter.sv
// Scoreboard bench for link_arbiter: master BFMs + slave model, monitor pops expected grants/bytes.
`timescale 1ns/1ps
module tb_link_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  m_req, m_done, m_ack, grant, spur_done, req_w, done_w;
  logic [15:0] m_data, data_w;
  logic        s_req, s_ack, busy, timeout;
  logic [7:0]  s_data;

  assign m_req  = req_w;
  assign m_done = done_w | spur_done;
  assign m_data = data_w;

  link_arbiter #(.N_MASTERS(2), .DATA_W(8), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_data(m_data), .m_done(m_done),
    .m_ack(m_ack), .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
    .grant(grant), .busy(busy), .timeout(timeout));

  logic [2:0]  m_req3, m_done3, m_ack3, grant3;
  logic [23:0] m_data3;
  logic        s_req3, s_ack3, busy3, timeout3;
  logic [7:0]  s_data3;

  link_arbiter #(.N_MASTERS(3), .DATA_W(8), .TIMEOUT_CYC(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .m_req(m_req3), .m_data(m_data3), .m_done(m_done3),
    .m_ack(m_ack3), .s_req(s_req3), .s_data(s_data3), .s_ack(s_ack3),
    .grant(grant3), .busy(busy3), .timeout(timeout3));

  typedef struct { logic [7:0] dat; logic [1:0] who; } exp_t;

  exp_t       exp_byte[$];
  logic [1:0] exp_grant[$];
  logic [2:0] exp_g3[$];
  exp_t       e;

  int checks = 0, fails = 0;
  int ordered[2], served[2];
  bit abort_all = 0, hang_ok = 0, slave_en = 1, gap_chk = 1;
  int multihot = 0, to_seen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_val(input int g, input int b, input int k);
    return 8'((g == 0 ? 160 : 16) + 8 * b + k);
  endfunction

  // Master BFMs: one 4-phase burst per ordered entry, done pulsed with the last req drop.
  for (genvar g = 0; g < 2; g++) begin : mst
    logic       req_g, done_g;
    logic [7:0] dat_g;
    int         n, lim;
    bit         quit;
    assign req_w[g]          = req_g;
    assign done_w[g]         = done_g;
    assign data_w[g*8 +: 8]  = dat_g;
    initial begin
      req_g = 1'b0; done_g = 1'b0; dat_g = 8'h00;
      forever begin
        @(posedge clk);
        if (served[g] < ordered[g]) begin
          quit = 0;
          for (int k = 0; k < 4 && !quit; k++) begin
            #1; dat_g = byte_val(g, served[g], k); req_g = 1'b1;
            lim = (hang_ok && g == 0) ? 12 : 400;
            n = 0;
            do begin @(negedge clk); n++; end while (!m_ack[g] && !abort_all && n < lim);
            if (!m_ack[g]) begin
              req_g = 1'b0;
              quit  = 1;
              if (!abort_all && !(hang_ok && g == 0)) begin
                checks++; fails++;
                $display("FAIL bfm%0d_ack_wait: got no ack required ack within %0d cycles", g, lim);
              end
            end else begin
              @(posedge clk); #1; req_g = 1'b0; done_g = (k == 3);
              @(posedge clk); #1; done_g = 1'b0;
              n = 0;
              do begin @(negedge clk); n++; end while (m_ack[g] && n < 400);
              if (m_ack[g]) begin
                checks++; fails++;
                $display("FAIL bfm%0d_ack_drop: got ack high required ack low", g);
              end
              @(posedge clk);
            end
          end
          served[g]++;
        end
      end
    end
  end

  // Slave: ack follows req with one cycle of delay.
  logic slv_r;
  initial begin
    s_ack = 1'b0;
    forever begin
      @(negedge clk); slv_r = s_req;
      @(posedge clk); #2;
      s_ack = slave_en && rst_n && slv_r;
    end
  end

  // Monitor: grant rises and slave byte captures are checked against the queues.
  logic [1:0] prev_grant = 2'b00;
  logic [2:0] prev_g3 = 3'b000;
  logic       prev_ack = 1'b0;
  int         low_run = 0;
  bit         had_burst = 0;
  initial forever begin
    @(negedge clk);
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      if (exp_grant.size() == 0) begin
        checks++; fails++;
        $display("FAIL grant_unexpected: got %0b required none", grant);
      end else check("grant_seq", grant, exp_grant.pop_front());
      if (had_burst && gap_chk) check("sreq_gap_ge2", low_run >= 2, 1);
      had_burst = 1;
    end
    if (s_ack && !prev_ack) begin
      if (exp_byte.size() == 0) begin
        checks++; fails++;
        $display("FAIL byte_unexpected: got %0h required none", s_data);
      end else begin
        e = exp_byte.pop_front();
        check("byte_data", s_data, e.dat);
        check("byte_m_ack", m_ack, e.who);
        check("byte_grant", grant, e.who);
      end
    end
    if (grant3 != 3'b000 && prev_g3 == 3'b000) begin
      if (exp_g3.size() == 0) begin
        checks++; fails++;
        $display("FAIL grant3_unexpected: got %0b required none", grant3);
      end else check("grant3_seq", grant3, exp_g3.pop_front());
    end
    if ((grant & (grant - 2'd1)) != 2'b00) multihot++;
    if (timeout) to_seen++;
    low_run    = s_req ? 0 : low_run + 1;
    prev_grant = grant;
    prev_g3    = grant3;
    prev_ack   = s_ack;
  end

  task automatic order(input int g, input int nbytes);
    exp_t x;
    exp_grant.push_back(2'(1 << g));
    for (int k = 0; k < nbytes; k++) begin
      x.dat = byte_val(g, ordered[g], k);
      x.who = 2'(1 << g);
      exp_byte.push_back(x);
    end
    ordered[g]++;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(served[0] == ordered[0] && served[1] == ordered[1] && !busy) && n < 3000);
    check(nm, (served[0] == ordered[0] && served[1] == ordered[1] && !busy), 1);
  endtask

  task automatic wait_byte(input logic [7:0] v, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(s_req && s_data == v) && n < 500);
    check(nm, (s_req && s_data == v), 1);
  endtask

  task automatic wait3(input logic [2:0] v, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (grant3 != v && n < 20);
    check(nm, grant3, v);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish required finish");
    $fatal(1, "time limit");
  end

  int b, n;
  initial begin
    rst_n = 1'b0; spur_done = 2'b00;
    m_req3 = 3'b000; m_done3 = 3'b000; m_data3 = 24'h332211; s_ack3 = 1'b0;
    ordered[0] = 0; ordered[1] = 0; served[0] = 0; served[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_s_req", s_req, 0);
    check("rst_timeout", timeout, 0);
    check("rst_grant3", grant3, 3'b000);
    rst_n = 1'b1;

    // N=3: masters 1,2 request with rr=2 -> 1; then 2; then wrap 2->0.
    exp_g3.push_back(3'b010);
    @(posedge clk); #1; m_req3 = 3'b110;
    @(negedge clk); check("g3_latency_pre", grant3, 3'b000);
    @(negedge clk); check("g3_first_m1", grant3, 3'b010);
    check("g3_s_data", s_data3, 8'h22);
    check("g3_s_req", s_req3, 1);
    check("g3_busy", busy3, 1);
    exp_g3.push_back(3'b100);
    @(posedge clk); #1; m_done3 = 3'b010; m_req3 = 3'b100;
    @(posedge clk); #1; m_done3 = 3'b000;
    wait3(3'b100, "g3_next_m2");
    exp_g3.push_back(3'b001);
    @(posedge clk); #1; m_done3 = 3'b100; m_req3 = 3'b011;
    @(posedge clk); #1; m_done3 = 3'b000;
    wait3(3'b001, "g3_wrap_to_m0");
    @(posedge clk); #1; m_done3 = 3'b001; m_req3 = 3'b000;
    @(posedge clk); #1; m_done3 = 3'b000;
    wait3(3'b000, "g3_release");

    // Both masters request in the same cycle after reset: 0 then 1.
    @(negedge clk); order(0, 4); order(1, 4);
    wait_idle("simul_done");
    // Continuous re-request: 0,1,0,1.
    order(0, 4); order(1, 4); order(0, 4); order(1, 4);
    wait_idle("rotate_done");
    // Master 0 alone.
    order(0, 4);
    wait_idle("single_done");
    check("single_grant_clr", grant, 2'b00);
    check("single_busy_clr", busy, 0);

    // Spurious done from master 1 mid-burst of master 0.
    b = ordered[0];
    order(0, 4);
    wait_byte(byte_val(0, b, 1), "spur_reach_b1");
    @(posedge clk); #1; spur_done = 2'b10;
    @(posedge clk); #1; spur_done = 2'b00;
    @(negedge clk);
    check("spur_grant_held", grant, 2'b01);
    check("spur_busy_held", busy, 1);
    wait_idle("spur_done");

    // Reset while byte 2 is being requested.
    b = ordered[0];
    order(0, 2);
    wait_byte(byte_val(0, b, 2), "rst_reach_b2");
    rst_n = 1'b0; abort_all = 1;
    @(negedge clk);
    check("midrst_grant", grant, 2'b00);
    check("midrst_s_req", s_req, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (served[0] != ordered[0] && n < 50);
    check("midrst_bfm_abort", served[0], ordered[0]);
    abort_all = 0;
    order(0, 4);
    wait_idle("postrst_done");

`ifdef ARB_TIMEOUT_EN
    // Hung master 0, master 1 waiting.
    gap_chk = 0; slave_en = 0; hang_ok = 1;
    order(0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (grant != 2'b01 && n < 50);
    check("to_grant_m0", grant, 2'b01);
    order(1, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout && n < 40);
    check("to_latency", n, 8);
    @(negedge clk);
    check("to_grant_clr", grant, 2'b00);
    check("to_pulse_1cyc", timeout, 0);
    slave_en = 1;
    wait_idle("to_m1_done");
    hang_ok = 0; gap_chk = 1;
    check("to_seen_once", to_seen, 1);
`else
    check("to_never", to_seen, 0);
`endif

    repeat (5) @(negedge clk);
    check("exp_bytes_drained", exp_byte.size(), 0);
    check("exp_grants_drained", exp_grant.size(), 0);
    check("exp_g3_drained", exp_g3.size(), 0);
    check("never_multihot", multihot, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
